// File: rtl/fcvt_sequencer_if.sv
// Request, conversion-unit and response signals of the int<->float conversion sequencer.
interface fcvt_sequencer_if;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_operand;
    logic [4:0]  req_rd;
    logic        req_ready;
    logic        flush;
    logic        conv_start;
    logic [1:0]  conv_op;
    logic [31:0] conv_operand;
    logic [31:0] conv_i2f_res;
    logic [31:0] conv_f2i_res;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        busy;

    // Sequencer side.
    modport slave (
        input  req_valid, req_op, req_operand, req_rd, flush,
        input  conv_i2f_res, conv_f2i_res, rsp_ready,
        output req_ready, conv_start, conv_op, conv_operand,
        output rsp_valid, rsp_data, rsp_rd, busy
    );

    // Pipeline / conversion-unit side.
    modport master (
        output req_valid, req_op, req_operand, req_rd, flush,
        output conv_i2f_res, conv_f2i_res, rsp_ready,
        input  req_ready, conv_start, conv_op, conv_operand,
        input  rsp_valid, rsp_data, rsp_rd, busy
    );
endinterface

// File: rtl/fcvt_sequencer.sv
// Sequences one request at a time through the shared multi-cycle int<->float unit.
module fcvt_sequencer #(
    parameter int unsigned I2F_CYCLES = 32,
    parameter int unsigned F2I_CYCLES = 1,
    parameter int unsigned CNT_W      = 6
) (
    input  logic            clk,
    input  logic            rst,
    fcvt_sequencer_if.slave bus
);
    localparam logic [1:0] OP_I2F = 2'b01;
    localparam logic [1:0] OP_F2I = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_last;
    logic [1:0]       op_q;
    logic [31:0]      operand_q;
    logic [4:0]       rd_q;
    logic             ready;
    logic             legal;
    logic             accept;
    logic             last;

    // Handshake decode: ready only when idle or when the pending result is being consumed.
    always_comb begin
        ready    = ((state == IDLE) || ((state == DONE) && bus.rsp_ready)) && !bus.flush;
        legal    = (bus.req_op == OP_I2F) || (bus.req_op == OP_F2I);
        accept   = bus.req_valid && ready && legal;
        cnt_last = (op_q == OP_I2F) ? CNT_W'(I2F_CYCLES - 1) : CNT_W'(F2I_CYCLES - 1);
        last     = (state == RUN) && (cnt == cnt_last);
    end

    assign bus.req_ready    = ready;
    assign bus.conv_op      = op_q;
    assign bus.conv_operand = operand_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides everything except reset.
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_nxt = RUN;
                RUN:  if (last)   state_nxt = DONE;
                DONE: begin
                    if (accept) begin
                        state_nxt = RUN;
                    end else if (bus.rsp_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.rsp_valid = (state == DONE);
    end

    // Operand hold, iteration counter, start pulse and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q           <= 2'b00;
            operand_q      <= 32'd0;
            rd_q           <= 5'd0;
            cnt            <= '0;
            bus.conv_start <= 1'b0;
            bus.rsp_data   <= 32'd0;
            bus.rsp_rd     <= 5'd0;
        end else begin
            bus.conv_start <= accept;
            if (accept) begin
                op_q      <= bus.req_op;
                operand_q <= bus.req_operand;
                rd_q      <= bus.req_rd;
                cnt       <= '0;
            end else if (bus.flush) begin
                cnt <= '0;
            end else if ((state == RUN) && !last) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (last && !bus.flush) begin
                bus.rsp_data <= (op_q == OP_I2F) ? bus.conv_i2f_res : bus.conv_f2i_res;
                bus.rsp_rd   <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_fcvt_sequencer.sv
// Directed bench for fcvt_sequencer with a table-driven model of the conversion unit.
module tb_fcvt_sequencer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fcvt_sequencer_if bus ();

    fcvt_sequencer #(.I2F_CYCLES(32), .F2I_CYCLES(1), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] i2f_tab(input logic [31:0] x);
        case (x)
            32'h0000_0005: return 32'h40A0_0000;
            32'hFFFF_FFFB: return 32'hC0A0_0000;
            32'h0000_0003: return 32'h4040_0000;
            default:       return 32'hDEAD_0001;
        endcase
    endfunction

    function automatic logic [31:0] f2i_tab(input logic [31:0] x);
        case (x)
            32'h40A0_0000: return 32'h0000_0005;
            32'hC0A0_0000: return 32'hFFFF_FFFB;
            default:       return 32'hDEAD_0002;
        endcase
    endfunction

    // Conversion unit model: results follow the held operand.
    always_comb begin
        bus.conv_i2f_res = i2f_tab(bus.conv_operand);
        bus.conv_f2i_res = f2i_tab(bus.conv_operand);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request at the current negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] operand, input logic [4:0] rd);
        bus.req_valid   = 1'b1;
        bus.req_op      = op;
        bus.req_operand = operand;
        bus.req_rd      = rd;
        #1;
        check("issue_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Starting in cycle 1 after accept, wait for rsp_valid; lat counts cycles since accept.
    task automatic wait_rsp(output int lat, output int starts, output int rdy_hi);
        lat    = 1;
        starts = 0;
        rdy_hi = 0;
        while (!bus.rsp_valid && lat < 100) begin
            starts += int'(bus.conv_start);
            rdy_hi += int'(bus.req_ready);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int starts;
        int rdy_hi;
        int bad;
        logic [31:0] held;

        n_tests         = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_op      = 2'b00;
        bus.req_operand = 32'd0;
        bus.req_rd      = 5'd0;
        bus.flush       = 1'b0;
        bus.rsp_ready   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_conv_start", 32'(bus.conv_start), 32'd0);
        check("rst_conv_op", 32'(bus.conv_op), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);

        // 1: I2F 5 -> 0x40A00000, rd 7
        issue(2'b01, 32'h0000_0005, 5'd7);
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_conv_operand", bus.conv_operand, 32'h0000_0005);
        check("t1_conv_op", 32'(bus.conv_op), 32'd1);
        wait_rsp(lat, starts, rdy_hi);
        check("t1_latency", 32'(lat), 32'd33);
        check("t1_ready_while_run", 32'(rdy_hi), 32'd0);
        check("t1_data", bus.rsp_data, 32'h40A0_0000);
        check("t1_rd", 32'(bus.rsp_rd), 32'd7);
        @(negedge clk);
        check("t1_valid_one_cycle", 32'(bus.rsp_valid), 32'd0);
        check("t1_idle", 32'(bus.busy), 32'd0);

        // 2: I2F -5 -> 0xC0A00000, single start pulse
        issue(2'b01, 32'hFFFF_FFFB, 5'd2);
        wait_rsp(lat, starts, rdy_hi);
        check("t2_latency", 32'(lat), 32'd33);
        check("t2_starts", 32'(starts), 32'd1);
        check("t2_data", bus.rsp_data, 32'hC0A0_0000);
        check("t2_rd", 32'(bus.rsp_rd), 32'd2);
        @(negedge clk);

        // 3: F2I both signs, two-cycle latency
        issue(2'b10, 32'h40A0_0000, 5'd11);
        wait_rsp(lat, starts, rdy_hi);
        check("t3a_latency", 32'(lat), 32'd2);
        check("t3a_data", bus.rsp_data, 32'h0000_0005);
        check("t3a_rd", 32'(bus.rsp_rd), 32'd11);
        @(negedge clk);
        issue(2'b10, 32'hC0A0_0000, 5'd12);
        wait_rsp(lat, starts, rdy_hi);
        check("t3b_latency", 32'(lat), 32'd2);
        check("t3b_data", bus.rsp_data, 32'hFFFF_FFFB);
        @(negedge clk);

        // 4: back-pressure in DONE, then back-to-back accept
        bus.rsp_ready = 1'b0;
        issue(2'b01, 32'h0000_0003, 5'd4);
        wait_rsp(lat, starts, rdy_hi);
        check("t4_latency", 32'(lat), 32'd33);
        held = bus.rsp_data;
        check("t4_data", held, 32'h4040_0000);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_data !== held || bus.req_ready || bus.rsp_rd !== 5'd4) bad++;
        end
        check("t4_hold_stable", 32'(bad), 32'd0);
        bus.rsp_ready = 1'b1;
        issue(2'b10, 32'h40A0_0000, 5'd6);
        check("t4_b2b_running", 32'(bus.busy), 32'd1);
        check("t4_b2b_no_valid", 32'(bus.rsp_valid), 32'd0);
        check("t4_b2b_start", 32'(bus.conv_start), 32'd1);
        check("t4_b2b_operand", bus.conv_operand, 32'h40A0_0000);
        wait_rsp(lat, starts, rdy_hi);
        check("t4_b2b_latency", 32'(lat), 32'd2);
        check("t4_b2b_data", bus.rsp_data, 32'h0000_0005);
        check("t4_b2b_rd", 32'(bus.rsp_rd), 32'd6);
        @(negedge clk);

        // 5: flush at RUN cycle 12 with a same-cycle request
        issue(2'b01, 32'h0000_0005, 5'd9);
        repeat (11) @(negedge clk);
        bus.flush       = 1'b1;
        bus.req_valid   = 1'b1;
        bus.req_op      = 2'b01;
        bus.req_operand = 32'h0000_0003;
        #1;
        check("t5_ready_on_flush", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        check("t5_idle_after_flush", 32'(bus.busy), 32'd0);
        check("t5_no_start", 32'(bus.conv_start), 32'd0);
        bad = 0;
        repeat (40) begin
            if (bus.rsp_valid || bus.busy) bad++;
            @(negedge clk);
        end
        check("t5_no_rsp", 32'(bad), 32'd0);
        issue(2'b01, 32'h0000_0003, 5'd10);
        wait_rsp(lat, starts, rdy_hi);
        check("t5_next_latency", 32'(lat), 32'd33);
        check("t5_next_data", bus.rsp_data, 32'h4040_0000);
        check("t5_next_rd", 32'(bus.rsp_rd), 32'd10);
        @(negedge clk);

        // 6: reset mid-RUN, then illegal ops ignored
        issue(2'b01, 32'hFFFF_FFFB, 5'd15);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t6_conv_start", 32'(bus.conv_start), 32'd0);
        check("t6_conv_op", 32'(bus.conv_op), 32'd0);
        check("t6_conv_operand", bus.conv_operand, 32'd0);
        check("t6_rsp_data", bus.rsp_data, 32'd0);
        check("t6_rsp_rd", 32'(bus.rsp_rd), 32'd0);
        bus.req_valid   = 1'b1;
        bus.req_op      = 2'b11;
        bus.req_operand = 32'h0000_0005;
        bus.req_rd      = 5'd1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus.conv_start || bus.conv_op !== 2'b00) bad++;
        end
        bus.req_op = 2'b00;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus.conv_start || bus.conv_op !== 2'b00) bad++;
        end
        check("t6_illegal_ignored", 32'(bad), 32'd0);
        check("t6_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.rsp_valid) bad++;
        end
        check("t6_no_rsp", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
